// File: rtl/iomem_gpio_pkg.sv
// Shared register map and helpers for the iomem GPIO block.
package gpio_pkg;

  localparam logic [3:0] GPIO_OUT     = 4'h0;
  localparam logic [3:0] GPIO_OE      = 4'h1;
  localparam logic [3:0] GPIO_IN      = 4'h2;
  localparam logic [3:0] GPIO_SET     = 4'h3;
  localparam logic [3:0] GPIO_CLR     = 4'h4;
  localparam logic [3:0] GPIO_TGL     = 4'h5;
  localparam logic [3:0] GPIO_RISE_EN = 4'h6;
  localparam logic [3:0] GPIO_FALL_EN = 4'h7;
  localparam logic [3:0] GPIO_STATUS  = 4'h8;

  function automatic logic [31:0] strb_mask(
    input logic [3:0] s
  );
    return {{8{s[3]}}, {8{s[2]}},
            {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// picosoc iomem bus bundle.
// One request per ready pulse; wstrb of 0 means read.
interface iomem_gpio_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/iomem_gpio_sync_edge.sv
// Pad synchroniser with a trailing prev flop.
// Edges are sync against prev, so a pad edge shows up SYNC_STAGES cycles later.
module gpio_sync_edge #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [SYNC_STAGES-1:0][W-1:0] r_ff;
  logic [W-1:0]                  r_prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ff   <= '0;
      r_prev <= '0;
    end else begin
      r_ff   <= {r_ff[SYNC_STAGES-2:0], i_d};
      r_prev <= r_ff[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_ff[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the picosoc iomem bus: OUT/OE, atomic set/clr/tgl,
// synchronised inputs and edge interrupts with write-1-to-clear status.
module iomem_gpio
  import gpio_pkg::*;
#(
  parameter int         N_GPIO      = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  iomem_gpio_if.slave       bus,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic              irq
);

  logic              r_ready;
  logic [31:0]       r_rdata;
  logic [N_GPIO-1:0] r_out;
  logic [N_GPIO-1:0] r_oe;
  logic [N_GPIO-1:0] r_re;
  logic [N_GPIO-1:0] r_fe;
  logic [N_GPIO-1:0] r_st;
  logic              r_irq;

  logic [N_GPIO-1:0] w_sync;
  logic [N_GPIO-1:0] w_rise;
  logic [N_GPIO-1:0] w_fall;

  logic              w_sel;
  logic              w_wr;
  logic [3:0]        w_idx;
  logic [31:0]       w_wm32;
  logic [N_GPIO-1:0] w_wm;
  logic [N_GPIO-1:0] w_wd;
  logic [31:0]       w_rd;

  logic [N_GPIO-1:0] w_out_n;
  logic [N_GPIO-1:0] w_oe_n;
  logic [N_GPIO-1:0] w_re_n;
  logic [N_GPIO-1:0] w_fe_n;
  logic [N_GPIO-1:0] w_clr;
  logic [N_GPIO-1:0] w_set;
  logic [N_GPIO-1:0] w_st_n;
  logic              w_unused;

  gpio_sync_edge #(
    .W           (N_GPIO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (gpio_in),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // The ack cycle itself never selects, forcing a gap between accesses.
  assign w_sel = bus.valid && !r_ready &&
                 (bus.addr[31:24] == BASE_ADDR);
  assign w_wr   = w_sel && (bus.wstrb != 4'h0);
  assign w_idx  = bus.addr[5:2];
  assign w_wm32 = strb_mask(bus.wstrb);
  assign w_wm   = w_wm32[N_GPIO-1:0];
  assign w_wd   = bus.wdata[N_GPIO-1:0] & w_wm;

  assign w_unused = &{1'b0, bus.addr[23:6],
                      bus.addr[1:0], bus.wdata,
                      w_wm32};

  always_comb begin
    w_rd = '0;
    unique case (w_idx)
      GPIO_OUT:     w_rd[N_GPIO-1:0] = r_out;
      GPIO_OE:      w_rd[N_GPIO-1:0] = r_oe;
      GPIO_IN:      w_rd[N_GPIO-1:0] = w_sync;
      GPIO_RISE_EN: w_rd[N_GPIO-1:0] = r_re;
      GPIO_FALL_EN: w_rd[N_GPIO-1:0] = r_fe;
      GPIO_STATUS:  w_rd[N_GPIO-1:0] = r_st;
      default:      w_rd = '0;
    endcase
  end

  always_comb begin
    w_out_n = r_out;
    w_oe_n  = r_oe;
    w_re_n  = r_re;
    w_fe_n  = r_fe;
    w_clr   = '0;
    if (w_wr) begin
      unique case (w_idx)
        GPIO_OUT:     w_out_n = (r_out & ~w_wm) | w_wd;
        GPIO_SET:     w_out_n = r_out | w_wd;
        GPIO_CLR:     w_out_n = r_out & ~w_wd;
        GPIO_TGL:     w_out_n = r_out ^ w_wd;
        GPIO_OE:      w_oe_n  = (r_oe & ~w_wm) | w_wd;
        GPIO_RISE_EN: w_re_n  = (r_re & ~w_wm) | w_wd;
        GPIO_FALL_EN: w_fe_n  = (r_fe & ~w_wm) | w_wd;
        GPIO_STATUS:  w_clr   = w_wd;
        default:      w_clr   = '0;
      endcase
    end
  end

  // A fresh edge outranks a same-cycle clear.
  assign w_set  = (w_rise & r_re) | (w_fall & r_fe);
  assign w_st_n = (r_st & ~w_clr) | w_set;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_out   <= '0;
      r_oe    <= '0;
      r_re    <= '0;
      r_fe    <= '0;
      r_st    <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ready <= w_sel;
      if (w_sel) r_rdata <= w_rd;
      r_out   <= w_out_n;
      r_oe    <= w_oe_n;
      r_re    <= w_re_n;
      r_fe    <= w_fe_n;
      r_st    <= w_st_n;
      r_irq   <= |r_st;
    end
  end

  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;
  assign gpio_out  = r_out;
  assign gpio_oe   = r_oe;
  assign irq       = r_irq;

endmodule

// File: tb/tb_iomem_gpio.sv
// Bench for iomem_gpio: directed register/edge cases, then random traffic
// compared every cycle against a pad-history reference model.
module tb_iomem_gpio;

  localparam int         N    = 8;
  localparam logic [7:0] BASE = 8'h03;
  localparam int         SS   = 2;
  localparam logic [31:0] NM  =
    (N == 32) ? 32'hFFFF_FFFF : ((32'd1 << N) - 32'd1);

  logic         clk    = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] gpio_in = '0;
  logic [N-1:0] gpio_out;
  logic [N-1:0] gpio_oe;
  logic         irq;

  iomem_gpio_if bus();

  iomem_gpio #(
    .N_GPIO      (N),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (SS)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: pad samples per edge; sync lags SS edges, prev one more.
  logic [31:0] m_out, m_oe, m_re, m_fe, m_st, m_rdata;
  logic        m_ready, m_irq;
  logic [31:0] hist [8];
  int          cyc;
  bit          pad_rand;

  initial begin
    m_out = 0; m_oe = 0; m_re = 0; m_fe = 0;
    m_st = 0; m_rdata = 0; m_ready = 0; m_irq = 0;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    cyc = 8;
    pad_rand = 0;
  end

  task automatic model_edge();
    logic [31:0] sy, pv, rd, wm, wd, setv, clr;
    logic [7:0]  off;
    bit          sel, wr;
    cyc++;
    hist[cyc & 7] = 32'(gpio_in);
    if (!resetn) begin
      m_out = 0; m_oe = 0; m_re = 0; m_fe = 0;
      m_st = 0; m_rdata = 0; m_ready = 0; m_irq = 0;
      for (int k = 0; k <= SS; k++) hist[(cyc - k) & 7] = 0;
      return;
    end
    sy   = hist[(cyc - SS) & 7];
    pv   = hist[(cyc - SS - 1) & 7];
    setv = (sy & ~pv & m_re) | (~sy & pv & m_fe);
    sel  = bus.valid && !m_ready && (bus.addr[31:24] == BASE);
    wr   = sel && (bus.wstrb != 0);
    wm   = 0;
    for (int k = 0; k < 4; k++)
      if (bus.wstrb[k]) wm = wm | (32'hFF << (8 * k));
    wm  = wm & NM;
    wd  = bus.wdata & wm;
    off = {2'b00, bus.addr[5:2], 2'b00};
    case (off)
      8'h00:   rd = m_out;
      8'h04:   rd = m_oe;
      8'h08:   rd = sy;
      8'h18:   rd = m_re;
      8'h1C:   rd = m_fe;
      8'h20:   rd = m_st;
      default: rd = 0;
    endcase
    clr   = 0;
    m_irq = (m_st != 0);
    if (wr) begin
      case (off)
        8'h00: m_out = (m_out & ~wm) | wd;
        8'h04: m_oe  = (m_oe & ~wm) | wd;
        8'h0C: m_out = m_out | wd;
        8'h10: m_out = m_out & ~wd;
        8'h14: m_out = m_out ^ wd;
        8'h18: m_re  = (m_re & ~wm) | wd;
        8'h1C: m_fe  = (m_fe & ~wm) | wd;
        8'h20: clr   = wd;
        default: ;
      endcase
    end
    m_st    = (m_st & ~clr) | setv;
    m_ready = sel;
    if (sel) m_rdata = rd;
  endtask

  task automatic tick();
    if (pad_rand && $urandom_range(3) == 0)
      gpio_in = N'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", 32'(bus.ready), 32'(m_ready));
    chk("rdata", bus.rdata, m_rdata);
    chk("gpio_out", 32'(gpio_out), m_out);
    chk("gpio_oe", 32'(gpio_oe), m_oe);
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  function automatic logic [31:0] A(input logic [7:0] off);
    return {BASE, 16'h0, off};
  endfunction

  task automatic acc(input logic [31:0] a,
                     input logic [3:0]  s,
                     input logic [31:0] d,
                     output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = 0;
    bus.valid = 1'b1;
    bus.addr  = a;
    bus.wstrb = s;
    bus.wdata = d;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (bus.ready === 1'b1) begin
        got = 1;
        rd  = bus.rdata;
      end
    end
    chk("ack", 32'(got), 32'd1);
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    tick();
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] rd;
    acc(A(off), 4'hF, d, rd);
  endtask

  task automatic rdr(input logic [7:0] off, output logic [31:0] rd);
    acc(A(off), 4'h0, 32'h0, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;

    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    rdr(8'h00, rd); chk("rst_out", rd, 32'h0);
    rdr(8'h04, rd); chk("rst_oe", rd, 32'h0);
    rdr(8'h08, rd); chk("rst_in", rd, 32'h0);
    rdr(8'h20, rd); chk("rst_status", rd, 32'h0);
    chk("rst_oe_pins", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    wr(8'h00, 32'hA5); chk("seq_out", 32'(gpio_out), 32'hA5);
    wr(8'h0C, 32'h0A); chk("seq_set", 32'(gpio_out), 32'hAF);
    wr(8'h10, 32'h81); chk("seq_clr", 32'(gpio_out), 32'h2E);
    wr(8'h14, 32'hFF); chk("seq_tgl", 32'(gpio_out), 32'hD1);
    rdr(8'h0C, rd); chk("set_rd0", rd, 32'h0);

    acc(A(8'h04), 4'b0001, 32'hFFFF_FFFF, rd);
    rdr(8'h04, rd); chk("oe_strb", rd, 32'h0000_00FF);
    acc(A(8'h04), 4'b0000, 32'h1234_5600, rd);
    chk("oe_wstrb0_rd", rd, 32'h0000_00FF);
    rdr(8'h04, rd); chk("oe_nochg", rd, 32'h0000_00FF);

    wr(8'h18, 32'h01);
    wr(8'h1C, 32'h00);
    gpio_in[0] = 1'b1;
    repeat (3) tick();
    chk("irq_t3", 32'(irq), 32'h0);
    tick();
    chk("irq_t4", 32'(irq), 32'h1);
    rdr(8'h20, rd); chk("rise_status", rd, 32'h01);
    wr(8'h20, 32'h01);
    chk("w1c_irq", 32'(irq), 32'h0);
    gpio_in[0] = 1'b0;
    repeat (5) tick();
    chk("fall_off_irq", 32'(irq), 32'h0);
    rdr(8'h20, rd); chk("fall_off_st", rd, 32'h0);

    wr(8'h18, 32'h02);
    wr(8'h1C, 32'h02);
    gpio_in[1] = 1'b1;
    repeat (5) tick();
    gpio_in[1] = 1'b0;
    tick();
    tick();
    wr(8'h20, 32'h02);
    rdr(8'h20, rd); chk("set_wins", rd, 32'h02);
    wr(8'h20, 32'h02);
    rdr(8'h20, rd); chk("w1c_done", rd, 32'h0);

    bus.valid = 1'b1;
    bus.addr  = 32'h0400_0000;
    bus.wstrb = 4'h0;
    repeat (6) begin
      tick();
      chk("bad_base", 32'(bus.ready), 32'h0);
    end
    bus.valid = 1'b0;
    tick();
    rdr(8'h3C, rd); chk("hole_rd", rd, 32'h0);

    wr(8'h00, 32'h5A);
    bus.valid = 1'b1;
    bus.addr  = A(8'h00);
    bus.wstrb = 4'h0;
    resetn    = 1'b0;
    tick();
    chk("rst_mid_ready", 32'(bus.ready), 32'h0);
    chk("rst_mid_out", 32'(gpio_out), 32'h0);
    bus.valid = 1'b0;
    resetn    = 1'b1;
    tick();
    rdr(8'h00, rd); chk("rst_mid_rd", rd, 32'h0);

    pad_rand = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) begin
        bus.valid = 1'b1;
        bus.addr  = {8'h04 + 8'($urandom_range(3)), 24'h0};
        bus.wstrb = 4'($urandom);
        repeat (2) tick();
        bus.valid = 1'b0;
        tick();
      end else begin
        acc(A(8'($urandom_range(15) << 2)),
            4'($urandom), $urandom, rd);
      end
      repeat ($urandom_range(2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
